// File: rtl/key_history_display.sv
// key_history_display
// Keeps the last two debounced key codes and time-multiplexes them onto a
// shared seven-segment bus. Slots are ordered right digit (newest), guard,
// left digit (previous), guard. During a guard slot both anodes are off so
// the old segment pattern cannot ghost onto the next digit.
// Optional feature: define LEADING_BLANK_EN to keep digits dark until a key
// has actually been captured into them.

module key_history_display #(
    parameter int MUX_BITS       = 15,
    parameter int GUARD_CYCLES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    // The counter must hold both the slot length and the guard length.
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int CNT_W   = (MUX_BITS > GUARD_W) ? MUX_BITS : GUARD_W;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'((64'd1 << MUX_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        SHOW_NEW = 2'd0,
        GUARD_A  = 2'd1,
        SHOW_OLD = 2'd2,
        GUARD_B  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] slot_cnt;
    logic             new_lit;
    logic             old_lit;

    // Hex to segment pattern in {g,f,e,d,c,b,a} order, then board polarity.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Two-entry key history: every valid cycle pushes the newest code in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else if (key_valid) begin
            digit_old <= digit_new;
            digit_new <= key_code;
        end
    end

`ifdef LEADING_BLANK_EN
    logic new_vld;
    logic old_vld;

    // Valid flags follow the history shift so a digit lights only once it holds a real key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_vld <= 1'b0;
            old_vld <= 1'b0;
        end else if (key_valid) begin
            old_vld <= new_vld;
            new_vld <= 1'b1;
        end
    end

    assign new_lit = new_vld;
    assign old_lit = old_vld;
`else
    assign new_lit = 1'b1;
    assign old_lit = 1'b1;
`endif

    // Slot sequencer: fixed-length slots, counter cleared on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SHOW_NEW;
            slot_cnt <= '0;
        end else begin
            unique case (state)
                SHOW_NEW: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        state    <= HAS_GUARD ? GUARD_A : SHOW_OLD;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                GUARD_A: begin
                    if (slot_cnt == GUARD_LAST) begin
                        slot_cnt <= '0;
                        state    <= SHOW_OLD;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                SHOW_OLD: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        state    <= HAS_GUARD ? GUARD_B : SHOW_NEW;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: begin
                    if (slot_cnt == GUARD_LAST) begin
                        slot_cnt <= '0;
                        state    <= SHOW_NEW;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered pin drivers: anode and segment pattern for the current slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 2'b11;
            seg <= SEG_OFF;
        end else begin
            unique case (state)
                SHOW_NEW: begin
                    an  <= 2'b10;
                    seg <= new_lit ? encode(digit_new) : SEG_OFF;
                end
                SHOW_OLD: begin
                    an  <= 2'b01;
                    seg <= old_lit ? encode(digit_old) : SEG_OFF;
                end
                default: begin
                    an  <= 2'b11;
                    seg <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_history_display.sv
// tb_key_history_display
// Two instances share the key stream: dut1 with a 2-cycle guard, dut2 with
// no guard. Short slots (16 cycles) keep the run brief. The reference model
// derives the expected slot from the cycle count since reset and the period
// formula, and keeps the key history as plain variables.
// Honours LEADING_BLANK_EN when the bench is built with it.

module tb_key_history_display;

    localparam int MB = 4;
    localparam int S  = 16;
    localparam int G1 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;

    logic [6:0] seg1, seg2;
    logic [1:0] an1, an2;
    logic [3:0] dn1, do1, dn2, do2;

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges since reset, history, number of captures (saturating).
    int         m_k    = 0;
    logic [3:0] m_new  = 4'h0;
    logic [3:0] m_old  = 4'h0;
    int         m_caps = 0;
    logic [1:0] exp_an1 = 2'b11, exp_an2 = 2'b11;
    logic [6:0] exp_seg1 = 7'h7F, exp_seg2 = 7'h7F;

    always #5 clk = ~clk;

    key_history_display #(.MUX_BITS(MB), .GUARD_CYCLES(G1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .seg(seg1), .an(an1), .digit_new(dn1), .digit_old(do1)
    );

    key_history_display #(.MUX_BITS(MB), .GUARD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .seg(seg2), .an(an2), .digit_new(dn2), .digit_old(do2)
    );

    // Expected pins after a cycle spent at position k of the period with guard length g.
    function automatic logic [8:0] expect_out(input int k, input int g, input logic [3:0] n,
                                              input logic [3:0] o, input int caps);
        int   p;
        logic lit_n, lit_o;
        p = k % (2 * (S + g));
`ifdef LEADING_BLANK_EN
        lit_n = (caps >= 1);
        lit_o = (caps >= 2);
`else
        lit_n = 1'b1;
        lit_o = (caps >= 0);
`endif
        if (p < S)              return {2'b10, lit_n ? ~hex_tab[n] : 7'h7F};
        else if (p < S + g)     return {2'b11, 7'h7F};
        else if (p < 2 * S + g) return {2'b01, lit_o ? ~hex_tab[o] : 7'h7F};
        else                    return {2'b11, 7'h7F};
    endfunction

    // Reference model advances once per clock edge, using pre-edge history for the pins.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k      <= 0;
            m_new    <= 4'h0;
            m_old    <= 4'h0;
            m_caps   <= 0;
            exp_an1  <= 2'b11;
            exp_seg1 <= 7'h7F;
            exp_an2  <= 2'b11;
            exp_seg2 <= 7'h7F;
        end else begin
            {exp_an1, exp_seg1} <= expect_out(m_k, G1, m_new, m_old, m_caps);
            {exp_an2, exp_seg2} <= expect_out(m_k, 0, m_new, m_old, m_caps);
            if (key_valid) begin
                m_old  <= m_new;
                m_new  <= key_code;
                m_caps <= (m_caps < 2) ? m_caps + 1 : m_caps;
            end
            m_k <= m_k + 1;
        end
    end

    // Reset values appear without a clock edge, and the first slot after release is the right digit.
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (an1 !== 2'b11) begin bad++; $display("[TB] FAIL reset_an got=%b want=11", an1); end
        total++; if (seg1 !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg got=%h want=7f", seg1); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (an1 !== 2'b10) begin bad++; $display("[TB] FAIL first_slot got=%b want=10", an1); end
        key_valid = 1'b1; key_code = 4'hC;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (an1 !== 2'b11) begin bad++; $display("[TB] FAIL async_an got=%b want=11", an1); end
        total++; if (seg1 !== 7'h7F) begin bad++; $display("[TB] FAIL async_seg got=%h want=7f", seg1); end
        total++; if (dn1 !== 4'h0 || do1 !== 4'h0) begin
            bad++; $display("[TB] FAIL async_digits got=%h/%h want=0/0", dn1, do1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (an1 !== 2'b10) begin bad++; $display("[TB] FAIL restart_slot got=%b want=10", an1); end
    endtask

    // Two presses build the history; each slot shows its own digit.
    task automatic test_capture();
        int n;
        key_valid = 1'b1; key_code = 4'h5;
        @(negedge clk);
        key_code = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        total++; if (dn1 !== 4'hA || do1 !== 4'h5) begin
            bad++; $display("[TB] FAIL capture_digits got=%h/%h want=a/5", dn1, do1);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (an1 !== 2'b10 && n < 100);
        total++; if (seg1 !== 7'h08) begin bad++; $display("[TB] FAIL right_seg got=%h want=08", seg1); end
        n = 0;
        do begin @(negedge clk); n++; end while (an1 !== 2'b01 && n < 100);
        total++; if (seg1 !== 7'h12) begin bad++; $display("[TB] FAIL left_seg got=%h want=12", seg1); end
    endtask

    // Measure one full period of an anode stream starting at a right-slot entry.
    task automatic measure_period(input bit use2, input int per, input int want11);
        int n, c10, c01, c11, c00, direct;
        logic [1:0] prev, cur;
        n = 0; prev = use2 ? an2 : an1;
        do begin
            @(negedge clk); n++;
            cur = use2 ? an2 : an1;
            if (cur === 2'b10 && prev !== 2'b10) break;
            prev = cur;
        end while (n < 200);
        c10 = 0; c01 = 0; c11 = 0; c00 = 0; direct = 0;
        for (int i = 0; i < per; i++) begin
            cur = use2 ? an2 : an1;
            if (cur === 2'b10) c10++;
            else if (cur === 2'b01) c01++;
            else if (cur === 2'b11) c11++;
            else c00++;
            if ((prev === 2'b10 && cur === 2'b01) || (prev === 2'b01 && cur === 2'b10)) direct++;
            prev = cur;
            @(negedge clk);
        end
        cur = use2 ? an2 : an1;
        total++; if (c10 !== S || c01 !== S) begin
            bad++; $display("[TB] FAIL slot_len(dut%0d) got=%0d/%0d want=%0d", use2 ? 2 : 1, c10, c01, S);
        end
        total++; if (c11 !== want11 || c00 !== 0) begin
            bad++; $display("[TB] FAIL gap_len(dut%0d) got=%0d off %0d zero want=%0d off 0 zero", use2 ? 2 : 1, c11, c00, want11);
        end
        total++; if (cur !== 2'b10 || prev === 2'b10) begin
            bad++; $display("[TB] FAIL period(dut%0d) got an=%b after %0d want=10", use2 ? 2 : 1, cur, per);
        end
        if (want11 != 0) begin
            total++; if (direct !== 0) begin bad++; $display("[TB] FAIL guard_skip got=%0d want=0", direct); end
        end else begin
            total++; if (direct !== 2) begin bad++; $display("[TB] FAIL direct_alt got=%0d want=2", direct); end
        end
    endtask

    // Guarded instance: 36-cycle period with two 2-cycle dark gaps.
    task automatic test_timing();
        measure_period(1'b0, 2 * (S + G1), 2 * G1);
    endtask

    // Guardless instance: 32-cycle period alternating straight between digits.
    task automatic test_no_guard();
        measure_period(1'b1, 2 * S, 0);
    endtask

    // Capture on the last left-slot cycle and a held key_valid level.
    task automatic test_boundary();
        int n;
        n = 0;
        while ((m_k % (2 * S)) != (2 * S - 1) && n < 100) begin @(negedge clk); n++; end
        total++; if (n >= 100) begin bad++; $display("[TB] FAIL boundary_sync got=timeout want=sync"); end
        key_valid = 1'b1; key_code = 4'h7;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        total++; if (an2 !== 2'b10 || seg2 !== 7'h78) begin
            bad++; $display("[TB] FAIL edge_capture got=%b/%h want=10/78", an2, seg2);
        end
        key_valid = 1'b1; key_code = 4'h3;
        @(negedge clk); key_code = 4'h4;
        @(negedge clk); key_code = 4'h5;
        @(negedge clk); key_valid = 1'b0;
        total++; if (dn1 !== 4'h5 || do1 !== 4'h4) begin
            bad++; $display("[TB] FAIL held_level got=%h/%h want=5/4", dn1, do1);
        end
    endtask

    // Random key traffic with one mid-run reset, every pin checked against the model each cycle.
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            total++; if (an1 !== exp_an1 || seg1 !== exp_seg1) begin
                bad++; $display("[TB] FAIL rand_pins1 cyc=%0d got=%b/%h want=%b/%h", i, an1, seg1, exp_an1, exp_seg1);
            end
            total++; if (an2 !== exp_an2 || seg2 !== exp_seg2) begin
                bad++; $display("[TB] FAIL rand_pins2 cyc=%0d got=%b/%h want=%b/%h", i, an2, seg2, exp_an2, exp_seg2);
            end
            total++; if (dn1 !== m_new || do1 !== m_old || dn2 !== m_new || do2 !== m_old) begin
                bad++; $display("[TB] FAIL rand_digits cyc=%0d got=%h/%h want=%h/%h", i, dn1, do1, m_new, m_old);
            end
            rst       = (i >= 400 && i < 403);
            key_valid = ($urandom_range(3) == 0);
            key_code  = 4'($urandom_range(15));
        end
        key_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_capture();
        test_timing();
        test_no_guard();
        test_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
